// File: rtl/tag_symbol_scheduler.sv
// ============================================================================
// Module   : tag_symbol_scheduler
// Purpose  : Queues 20-bit subcarrier symbols, performs a slotted-ALOHA
//            random backoff, then drives PREAMBLE + data (+ optional parity)
//            symbols into the backscatter modulator, followed by a guard gap.
//            Optional parity symbol: define TAG_SCHED_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tag_symbol_scheduler #(
    parameter int                WIDTH         = 20,
    parameter int                DEPTH         = 8,
    parameter int                SYMBOL_CYCLES = 64,
    parameter int                SLOT_CYCLES   = 256,
    parameter int                BACKOFF_BITS  = 4,
    parameter int                GUARD_CYCLES  = 16,
    parameter logic [WIDTH-1:0]  PREAMBLE      = 20'hAAAAA,
    parameter logic [15:0]       LFSR_SEED     = 16'hACE1
) (
    input  logic             input_clock,
    input  logic             reset,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] tag_data_word,
    output logic             tx_active,
    output logic             symbol_strobe,
    output logic             done
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = $clog2(DEPTH + 1);
    localparam int c_SYM_W  = $clog2(SYMBOL_CYCLES);
    localparam int c_GRD_W  = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam int c_BO_MAX = (2 ** BACKOFF_BITS - 1) * SLOT_CYCLES;
    localparam int c_BO_W   = $clog2(c_BO_MAX + 1);

    localparam logic [c_SYM_W-1:0] c_SYM_LAST = c_SYM_W'(SYMBOL_CYCLES - 1);
    localparam logic [c_GRD_W-1:0] c_GRD_LAST = c_GRD_W'(GUARD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(DEPTH);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_BACKOFF  = 3'd1;
    localparam logic [2:0] c_ST_PREAMBLE = 3'd2;
    localparam logic [2:0] c_ST_DATA     = 3'd3;
    localparam logic [2:0] c_ST_GUARD    = 3'd4;
`ifdef TAG_SCHED_PARITY_EN
    localparam logic [2:0] c_ST_PARITY   = 3'd5;
`endif

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_burst_len;
    logic [c_CNT_W-1:0] r_sent;
    logic [c_SYM_W-1:0] r_sym_cnt;
    logic [c_GRD_W-1:0] r_grd_cnt;
    logic [c_BO_W-1:0]  r_bo_cnt;
    logic [15:0]        r_lfsr;
    logic [15:0]        w_lfsr_nxt;
    logic               w_push;
    logic               w_pop;
    logic               w_accept;
    logic               w_sym_last;
    logic               w_in_symbol;
    logic [WIDTH-1:0]   w_head;
    logic [WIDTH-1:0]   w_word;
    logic               w_tx;
    logic               w_strobe;
    logic               w_done;
    logic               w_busy;
`ifdef TAG_SCHED_PARITY_EN
    logic [WIDTH-1:0]   r_parity;
`endif

    assign wr_ready    = (r_count != c_FULL);
    assign w_push      = wr_valid && wr_ready;
    assign w_head      = r_mem[r_rptr];
    assign w_sym_last  = (r_sym_cnt == c_SYM_LAST);
    // Right-shift Galois form of x^16+x^14+x^13+x^11+1
    assign w_lfsr_nxt  = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);

    always_ff @(posedge input_clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_pop       = 1'b0;
        w_in_symbol = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start && (r_count != '0)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_ST_BACKOFF;
                end
            end
            c_ST_BACKOFF: begin
                if (r_bo_cnt == '0) w_state_nxt = c_ST_PREAMBLE;
            end
            c_ST_PREAMBLE: begin
                w_in_symbol = 1'b1;
                if (w_sym_last) w_state_nxt = c_ST_DATA;
            end
            c_ST_DATA: begin
                w_in_symbol = 1'b1;
                if (w_sym_last) begin
                    w_pop = 1'b1;
                    if (r_sent == r_burst_len - c_CNT_W'(1)) begin
`ifdef TAG_SCHED_PARITY_EN
                        w_state_nxt = c_ST_PARITY;
`else
                        w_state_nxt = c_ST_GUARD;
`endif
                    end
                end
            end
`ifdef TAG_SCHED_PARITY_EN
            c_ST_PARITY: begin
                w_in_symbol = 1'b1;
                if (w_sym_last) w_state_nxt = c_ST_GUARD;
            end
`endif
            c_ST_GUARD: begin
                if (r_grd_cnt == c_GRD_LAST) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_word   = '0;
        w_tx     = 1'b0;
        w_strobe = 1'b0;
        w_done   = 1'b0;
        w_busy   = (r_state != c_ST_IDLE);
        case (r_state)
            c_ST_PREAMBLE: w_word = PREAMBLE;
            c_ST_DATA:     w_word = w_head;
`ifdef TAG_SCHED_PARITY_EN
            c_ST_PARITY:   w_word = r_parity;
`endif
            c_ST_GUARD:    w_done = (r_grd_cnt == c_GRD_LAST);
            default:       w_word = '0;
        endcase
        if (w_in_symbol) begin
            w_tx     = 1'b1;
            w_strobe = (r_sym_cnt == '0);
        end
    end

    // Storage array carries no reset; occupancy is tracked by r_count
    always_ff @(posedge input_clock) begin
        if (w_push) r_mem[r_wptr] <= wr_data;
    end

    always_ff @(posedge input_clock) begin
        if (reset) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_burst_len   <= '0;
            r_sent        <= '0;
            r_sym_cnt     <= '0;
            r_grd_cnt     <= '0;
            r_bo_cnt      <= '0;
            r_lfsr        <= LFSR_SEED;
            tag_data_word <= '0;
            tx_active     <= 1'b0;
            symbol_strobe <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
`ifdef TAG_SCHED_PARITY_EN
            r_parity      <= '0;
`endif
        end else begin
            r_lfsr        <= w_lfsr_nxt;
            tag_data_word <= w_word;
            tx_active     <= w_tx;
            symbol_strobe <= w_strobe;
            done          <= w_done;
            busy          <= w_busy;

            if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + c_CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - c_CNT_W'(1);

            r_sym_cnt <= (w_in_symbol && !w_sym_last) ? r_sym_cnt + c_SYM_W'(1) : '0;
            r_grd_cnt <= (r_state == c_ST_GUARD && r_grd_cnt != c_GRD_LAST)
                         ? r_grd_cnt + c_GRD_W'(1) : '0;

            if (w_accept) begin
                r_burst_len <= r_count;
                r_sent      <= '0;
                r_bo_cnt    <= c_BO_W'(32'(r_lfsr[BACKOFF_BITS-1:0]) * SLOT_CYCLES);
`ifdef TAG_SCHED_PARITY_EN
                r_parity    <= '0;
`endif
            end else if (r_state == c_ST_BACKOFF && r_bo_cnt != '0) begin
                r_bo_cnt <= r_bo_cnt - c_BO_W'(1);
            end

            if (w_pop) begin
                r_sent   <= r_sent + c_CNT_W'(1);
`ifdef TAG_SCHED_PARITY_EN
                r_parity <= r_parity ^ w_head;
`endif
            end
        end
    end

endmodule

`default_nettype wire
